// File: rtl/servant_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter with TX FIFO.
// Store cycles push bytes; a baud-divided serializer drains them onto o_tx.
module servant_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd276
) (
  input  logic        wb_clk,
  input  logic        wb_rstn,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level;
  logic          ovf;
  logic          irq_en;
  logic [15:0]   div;
  logic [15:0]   cnt;
  logic [7:0]    shift;
  logic [2:0]    bitcnt;

  logic          full;
  logic          empty;
  logic          busy;
  logic          acc;
  logic          wr;
  logic          sel_data;
  logic          sel_stat;
  logic          sel_div;
  logic          sel_ctrl;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          bit_end;
  logic [3:0]    lvl4;
  logic [31:0]   rd;
  logic          unused;

  assign unused   = ^{i_wb_adr[1:0], i_wb_dat[31:16]};
  assign full     = level == FULL_LVL;
  assign empty    = level == '0;
  assign busy     = state != IDLE;
  assign lvl4     = 4'(level);
  assign acc      = i_wb_cyc & ~o_wb_ack;
  assign wr       = acc & i_wb_we;
  assign sel_data = i_wb_adr[3:2] == 2'd0;
  assign sel_stat = i_wb_adr[3:2] == 2'd1;
  assign sel_div  = i_wb_adr[3:2] == 2'd2;
  assign sel_ctrl = i_wb_adr[3:2] == 2'd3;
  assign push     = wr & sel_data;
  assign push_ok  = push & ~full;
  assign bit_end  = cnt == '0;
  assign pop      = ~empty &
                    ((state == IDLE) |
                     ((state == STOP) & bit_end));

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_data: rd = '0;
      sel_stat: begin
        rd[0]    = full;
        rd[1]    = empty;
        rd[2]    = busy;
        rd[3]    = ovf;
        rd[11:8] = lvl4;
      end
      sel_div:  rd[15:0] = div;
      sel_ctrl: rd[0] = irq_en;
      default:  rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rstn) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      ovf      <= 1'b0;
      irq_en   <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      o_wb_ack <= acc;
      o_wb_rdt <= (acc & ~i_wb_we) ? rd : '0;
      if (push & full)
        ovf <= 1'b1;
      else if (wr & sel_stat & i_wb_dat[3])
        ovf <= 1'b0;
      if (wr & sel_div)
        div <= i_wb_dat[15:0];
      if (wr & sel_ctrl)
        irq_en <= i_wb_dat[0];
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok)
      mem[wptr] <= i_wb_dat[7:0];
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(push_ok)
                     - (AW+1)'(pop);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rstn) begin
      state  <= IDLE;
      o_tx   <= 1'b1;
      cnt    <= '0;
      shift  <= '0;
      bitcnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (pop) begin
            shift  <= mem[rptr];
            bitcnt <= '0;
            cnt    <= div;
            state  <= START;
            o_tx   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= div;
            state <= DATA;
            o_tx  <= shift[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= div;
            if (bitcnt == 3'd7) begin
              state <= STOP;
              o_tx  <= 1'b1;
            end else begin
              shift  <= shift >> 1;
              bitcnt <= bitcnt + 1'b1;
              o_tx   <= shift[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // chain straight into the next start bit
            if (pop) begin
              shift  <= mem[rptr];
              bitcnt <= '0;
              cnt    <= div;
              state  <= START;
              o_tx   <= 1'b0;
            end else begin
              state <= IDLE;
              o_tx  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rstn)
      o_irq <= 1'b0;
    else
      o_irq <= irq_en & empty & ~busy;
  end

endmodule

// File: tb/tb_servant_uart_tx.sv
// Bench for servant_uart_tx: frame-level reference model
// with per-cycle comparison, directed cases and random traffic.
module tb_servant_uart_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic        we;
  logic        cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_tx;
  logic        o_irq;

  servant_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd276)
  ) dut (
    .wb_clk  (clk),
    .wb_rstn (rstn),
    .i_wb_adr(adr),
    .i_wb_dat(dat),
    .i_wb_we (we),
    .i_wb_cyc(cyc),
    .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack),
    .o_tx    (o_tx),
    .o_irq   (o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;
  int ncyc   = 0;
  int ack_cyc;
  logic tx_hist [1024];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s actual=%h expected=%h t=%0t",
                 name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the frame currently on the wire.
  logic [7:0] mq[$];
  bit          m_ack, m_ovf, m_irqen, m_irq, m_busy, m_tx;
  logic [31:0] m_rdt;
  int          m_div;
  logic [9:0]  m_frame;
  int          m_idx, m_age, m_dur;

  task automatic start_frame(input logic [7:0] b);
    m_frame = {1'b1, b, 1'b0};
    m_idx   = 0;
    m_age   = 0;
    m_dur   = m_div + 1;
    m_busy  = 1'b1;
  endtask

  always @(posedge clk) begin
    bit   acc, pfull, pempty, pbusy;
    int   plevel;
    logic [3:0] lv;
    ncyc++;
    if (!rstn) begin
      mq.delete();
      m_ack = 0; m_rdt = 0; m_ovf = 0; m_irqen = 0;
      m_irq = 0; m_busy = 0; m_div = 276;
    end else begin
      plevel = mq.size();
      pfull  = plevel == DEPTH;
      pempty = plevel == 0;
      pbusy  = m_busy;
      acc    = cyc && !m_ack;
      m_irq  = m_irqen && pempty && !pbusy;
      if (!m_busy) begin
        if (!pempty) start_frame(mq.pop_front());
      end else begin
        m_age++;
        if (m_age == m_dur) begin
          m_idx++;
          if (m_idx == 10) begin
            if (!pempty) start_frame(mq.pop_front());
            else m_busy = 1'b0;
          end else begin
            m_dur = m_div + 1;
            m_age = 0;
          end
        end
      end
      m_ack = acc;
      m_rdt = 0;
      if (acc && !we) begin
        case (adr[3:2])
          2'd1: begin
            lv = 4'(plevel);
            m_rdt = {20'b0, lv, 4'b0, m_ovf, pbusy, pempty, pfull};
          end
          2'd2: m_rdt = 32'(m_div);
          2'd3: m_rdt = 32'(m_irqen);
          default: m_rdt = 0;
        endcase
      end
      if (acc && we) begin
        case (adr[3:2])
          2'd0: if (pfull) m_ovf = 1; else mq.push_back(dat[7:0]);
          2'd1: if (dat[3]) m_ovf = 0;
          2'd2: m_div = int'(dat[15:0]);
          default: m_irqen = dat[0];
        endcase
      end
    end
    m_tx = m_busy ? m_frame[m_idx] : 1'b1;
  end

  always @(negedge clk) begin
    tx_hist[ncyc % 1024] = o_tx;
    if (chk_on) begin
      chk("tx", 32'(o_tx), 32'(m_tx));
      chk("ack", 32'(o_wb_ack), 32'(m_ack));
      chk("irq", 32'(o_irq), 32'(m_irq));
      if (m_ack) chk("rdt", o_wb_rdt, m_rdt);
    end
  end

  task automatic bus(input logic [3:0] a, input logic w,
                     input logic [31:0] d, output logic [31:0] r);
    bit got = 0;
    adr = a; we = w; dat = d; cyc = 1'b1; r = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (o_wb_ack) begin
        got = 1; r = o_wb_rdt; ack_cyc = ncyc;
      end
    end
    cyc = 1'b0; we = 1'b0;
    if (!got) chk("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 1'b1, d, r);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    bus(a, 1'b0, 32'd0, r);
  endtask

  task automatic check_wave(input string name, input int t0,
                            input int dur, input logic [9:0] f);
    int bad = -1;
    for (int k = 0; k < 10 * dur; k++)
      if (bad < 0 && tx_hist[(t0 + k) % 1024] !== f[k / dur])
        bad = k;
    chk(name, bad, -1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((m_busy || mq.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(m_busy || mq.size() != 0), 32'd0);
  endtask

  task automatic pulse_reset();
    cyc = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int t0;
    rstn = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk_on = 1'b1;

    rd(4'h4, r); chk("rst_status", r, 32'h2);
    rd(4'h8, r); chk("rst_div", r, 32'd276);
    chk("rst_tx", 32'(o_tx), 32'd1);
    wr(4'hC, 32'h1);
    chk("irq_pre", 32'(o_irq), 32'd0);
    @(negedge clk);
    chk("irq_lat", 32'(o_irq), 32'd1);

    wr(4'h8, 32'd3);
    wr(4'h0, 32'hA5);
    t0 = ack_cyc + 1;
    repeat (40) @(negedge clk);
    rd(4'h4, r); chk("a5_busy_end", r, 32'h6);
    check_wave("wave_a5", t0, 4, 10'b1101001010);
    rd(4'h4, r); chk("a5_idle", r, 32'h2);

    wr(4'h8, 32'd1);
    wr(4'h0, 32'h55);
    t0 = ack_cyc + 1;
    wr(4'h0, 32'h0F);
    repeat (45) @(negedge clk);
    check_wave("wave_55", t0, 2, 10'b1010101010);
    check_wave("wave_0f", t0 + 20, 2, 10'b1000011110);

    wr(4'h8, 32'd1000);
    for (int i = 0; i < DEPTH + 2; i++)
      wr(4'h0, 32'($urandom_range(0, 255)));
    rd(4'h4, r); chk("ovf_status", r, 32'h80D);
    wr(4'h4, 32'h8);
    rd(4'h4, r); chk("ovf_clear", r, 32'h805);
    wr(4'h8, 32'd1);
    drain("ovf_drain");

    wr(4'h8, 32'd3);
    wr(4'h0, 32'hFF);
    repeat (9) @(negedge clk);
    wr(4'h8, 32'd7);
    repeat (58) @(negedge clk);
    rd(4'h4, r); chk("divchg_busy", r, 32'h6);
    rd(4'h4, r); chk("divchg_idle", r, 32'h2);

    wr(4'h8, 32'd3);
    for (int i = 0; i < 4; i++) wr(4'h0, 32'(8'h30 + i));
    repeat (6) @(negedge clk);
    pulse_reset();
    chk("rst_mid_tx", 32'(o_tx), 32'd1);
    rd(4'h4, r); chk("rst_mid_status", r, 32'h2);
    rd(4'h8, r); chk("rst_mid_div", r, 32'd276);
    t0 = ncyc;
    repeat (62) @(negedge clk);
    check_wave("rst_quiet", t0, 6, 10'h3FF);

    wr(4'h8, 32'd1);
    for (int n = 0; n < 300; n++) begin
      int op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: wr(4'h0, $urandom);
        4: wr(4'h8, 32'($urandom_range(0, 2)));
        5: wr(4'hC, 32'($urandom_range(0, 1)));
        6: wr(4'h4, $urandom);
        7: rd(4'($urandom_range(0, 3) << 2), r);
        8: begin
          adr = 4'($urandom_range(0, 3) << 2);
          we  = 1'($urandom_range(0, 1));
          dat = (adr == 4'h8) ? 32'($urandom_range(0, 2))
                              : $urandom;
          cyc = 1'b1;
          repeat ($urandom_range(3, 7)) @(negedge clk);
          cyc = 1'b0; we = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 24) == 0) begin
            pulse_reset();
            wr(4'h8, 32'($urandom_range(0, 2)));
          end else begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
          end
        end
      endcase
    end
    drain("rand_drain");
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
